// File: rtl/mure_te_sequencer_if.sv
// Shared trace-entry types and the sequencer-to-encoder beat interface.
// The sequencer drives the beat through the master modport; the encoder side
// (or a testbench) uses the slave modport and returns te_ready.

package mure_te_pkg;

  localparam logic [3:0] ITYPE_STD = 4'd0;

  // One entry per retire cycle: privilege, trap cause and trap value
  typedef struct packed {
    logic [1:0]  priv;
    logic [7:0]  cause;
    logic [31:0] tval;
  } common_entry_s;

  // One entry per retired instruction
  typedef struct packed {
    logic [3:0]  itype;
    logic [2:0]  iretire;
    logic [31:0] iaddr;
  } uop_entry_s;

endpackage

interface mure_te_sequencer_if;
  import mure_te_pkg::*;

  logic          te_valid;
  logic          te_ready;
  uop_entry_s    te_uop;
  common_entry_s te_common;
  logic          te_last;

  modport master (output te_valid, te_uop, te_common, te_last, input te_ready);
  modport slave  (input te_valid, te_uop, te_common, te_last, output te_ready);
endinterface

// File: rtl/mure_te_sequencer.sv
// Trace encoder sequencer: merges the common FIFO (one entry per retire cycle)
// and the uop FIFO (one entry per retired instruction) into a single beat
// stream. Each block starts with one common pop, followed by its uops, or by a
// single all-zero beat when the block carries no uops.
// Optional feature: define MURE_SEQ_B2B_EN to pop the next common entry on the
// last-beat handshake and skip the IDLE bubble between blocks.

module mure_te_sequencer
  import mure_te_pkg::*;
#(
  parameter int NRET      = 2,
  parameter int CNT_W     = $clog2(NRET + 1),
  parameter int STALL_MAX = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  common_empty_i,
  input  common_entry_s         common_data_i,
  input  logic [CNT_W-1:0]      common_nuops_i,
  output logic                  common_pop_o,
  input  logic                  uop_empty_i,
  input  uop_entry_s            uop_data_i,
  output logic                  uop_pop_o,
  mure_te_sequencer_if.master   te,
  output logic                  error_o
);

  localparam int STALL_W = $clog2(STALL_MAX + 1);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(STALL_MAX);
  localparam logic [CNT_W-1:0]   NRET_CNT    = CNT_W'(NRET);

  typedef enum logic [1:0] {IDLE, STREAM, EMPTYBEAT} state_e;

  state_e               state_q, state_d;
  common_entry_s        common_q, common_d;
  logic [CNT_W-1:0]     rem_q, rem_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic                 error_q, error_d;

  logic                 commonPop, uopPop, beatValid, beatLast;
  logic                 takeNext, lastHs;
  uop_entry_s           beatUop;
  common_entry_s        beatCommon;
  logic [CNT_W-1:0]     nuopsClamped;

  // A corrupted count larger than the retire width is limited to NRET
  assign nuopsClamped = (common_nuops_i > NRET_CNT) ? NRET_CNT : common_nuops_i;

  // Next-state and beat outputs; flush overrides every transition and pop
  always_comb begin
    state_d    = state_q;
    common_d   = common_q;
    rem_d      = rem_q;
    stall_d    = stall_q;
    error_d    = error_q;
    commonPop  = 1'b0;
    uopPop     = 1'b0;
    beatValid  = 1'b0;
    beatLast   = 1'b0;
    beatUop    = '0;
    beatCommon = '0;
    takeNext   = 1'b0;
    lastHs     = 1'b0;

    case (state_q)
      IDLE: begin
        takeNext = !common_empty_i;
      end
      STREAM: begin
        beatValid  = !uop_empty_i;
        beatUop    = uop_data_i;
        beatCommon = common_q;
        beatLast   = (rem_q == CNT_W'(1));
        if (beatValid && te.te_ready) begin
          uopPop  = 1'b1;
          stall_d = '0;
          if (rem_q != '0) begin
            rem_d = rem_q - 1'b1;
          end
          if (rem_q <= CNT_W'(1)) begin
            state_d = IDLE;
            lastHs  = 1'b1;
          end
        end else if (uop_empty_i && (stall_q != STALL_LIMIT)) begin
          stall_d = stall_q + 1'b1;
        end
      end
      EMPTYBEAT: begin
        beatValid  = 1'b1;
        beatCommon = common_q;
        beatLast   = 1'b1;
        if (te.te_ready) begin
          state_d = IDLE;
          lastHs  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef MURE_SEQ_B2B_EN
    if (lastHs && !common_empty_i) begin
      takeNext = 1'b1;
    end
`else
    if (lastHs) begin
      takeNext = 1'b0;
    end
`endif

    if (takeNext) begin
      commonPop = 1'b1;
      common_d  = common_data_i;
      rem_d     = nuopsClamped;
      state_d   = (nuopsClamped != '0) ? STREAM : EMPTYBEAT;
    end

    if (state_d != STREAM) begin
      stall_d = '0;
    end

    if (stall_d == STALL_LIMIT) begin
      error_d = 1'b1;
    end

    if (flush_i) begin
      state_d   = IDLE;
      common_d  = common_q;
      rem_d     = '0;
      stall_d   = '0;
      commonPop = 1'b0;
      uopPop    = 1'b0;
      beatValid = 1'b0;
    end
  end

  // State, latched common entry and counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      common_q <= '0;
      rem_q    <= '0;
      stall_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      common_q <= common_d;
      rem_q    <= rem_d;
      stall_q  <= stall_d;
      error_q  <= error_d;
    end
  end

  // Handshake outputs are held low for the whole time reset is asserted
  assign common_pop_o = commonPop & rst_ni;
  assign uop_pop_o    = uopPop & rst_ni;
  assign te.te_valid  = beatValid & rst_ni;
  assign te.te_last   = beatLast;
  assign te.te_uop    = beatUop;
  assign te.te_common = beatCommon;
  assign error_o      = error_q;

endmodule

// File: tb/tb_mure_te_sequencer.sv
// Self-checking bench for mure_te_sequencer. The two trace FIFOs are modelled
// as queues; pushing a block also pushes its expected beats to a scoreboard
// that an independent monitor consumes on every handshake.

module tb_mure_te_sequencer;
  import mure_te_pkg::*;

  localparam int NRET      = 2;
  localparam int CNT_W     = 2;
  localparam int STALL_MAX = 4;

  typedef struct {
    common_entry_s    data;
    logic [CNT_W-1:0] nuops;
  } cmn_t;

  typedef struct {
    uop_entry_s    uop;
    common_entry_s common;
    logic          last;
    logic          hasUop;
  } beat_t;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_i;
  logic             common_empty_i;
  common_entry_s    common_data_i;
  logic [CNT_W-1:0] common_nuops_i;
  logic             common_pop_o;
  logic             uop_empty_i;
  uop_entry_s       uop_data_i;
  logic             uop_pop_o;
  logic             error_o;

  mure_te_sequencer_if teIf ();

  mure_te_sequencer #(.NRET(NRET), .CNT_W(CNT_W), .STALL_MAX(STALL_MAX)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .common_empty_i (common_empty_i),
    .common_data_i  (common_data_i),
    .common_nuops_i (common_nuops_i),
    .common_pop_o   (common_pop_o),
    .uop_empty_i    (uop_empty_i),
    .uop_data_i     (uop_data_i),
    .uop_pop_o      (uop_pop_o),
    .te             (teIf),
    .error_o        (error_o)
  );

  always #5 clk_i = ~clk_i;

  cmn_t       commonQ[$];
  uop_entry_s uopQ[$];
  uop_entry_s heldQ[$];
  beat_t      expQ[$];

  int checks = 0;
  int failures = 0;
  int beatsExpected = 0;
  int beatsSeen = 0;
  bit popCPend = 1'b0;
  bit popUPend = 1'b0;
  bit readyRandom = 1'b0;
  bit readyForce = 1'b1;
  uop_entry_s lastUop;

  // Compare one value and report a mismatch
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Push one block into the FIFO model and its expected beats into the scoreboard
  task automatic applyStimulus(input common_entry_s c, input int n, input bit withUops);
    cmn_t  ce;
    beat_t b;
    int    eff;
    ce.data  = c;
    ce.nuops = CNT_W'(n);
    commonQ.push_back(ce);
    eff = (n > NRET) ? NRET : n;
    if (eff == 0) begin
      b.uop = '0; b.common = c; b.last = 1'b1; b.hasUop = 1'b0;
      expQ.push_back(b);
      beatsExpected++;
    end else begin
      for (int i = 0; i < eff; i++) begin
        uop_entry_s u;
        u.itype = 4'($urandom); u.iretire = 3'($urandom); u.iaddr = $urandom | 32'h1;
        lastUop = u;
        if (withUops) uopQ.push_back(u);
        else heldQ.push_back(u);
        b.uop = u; b.common = c; b.last = (i == eff - 1); b.hasUop = 1'b1;
        expQ.push_back(b);
        beatsExpected++;
      end
    end
  endtask

  function automatic common_entry_s mkCommon(input logic [1:0] p, input logic [7:0] cs);
    common_entry_s c;
    c.priv = p; c.cause = cs; c.tval = $urandom;
    return c;
  endfunction

  task automatic driveInputs();
    common_empty_i = (commonQ.size() == 0);
    common_data_i  = (commonQ.size() == 0) ? '0 : commonQ[0].data;
    common_nuops_i = (commonQ.size() == 0) ? '0 : commonQ[0].nuops;
    uop_empty_i    = (uopQ.size() == 0);
    uop_data_i     = (uopQ.size() == 0) ? '0 : uopQ[0];
    teIf.te_ready  = readyRandom ? ($urandom_range(0, 3) != 0) : readyForce;
  endtask

  // FIFO model: apply the pops seen in the previous cycle, then present new heads
  initial begin
    driveInputs();
    forever begin
      @(posedge clk_i);
      #1;
      if (popCPend && commonQ.size() > 0) void'(commonQ.pop_front());
      if (popUPend && uopQ.size() > 0) void'(uopQ.pop_front());
      popCPend = 1'b0;
      popUPend = 1'b0;
      driveInputs();
    end
  end

  // Monitor: on every handshake pop the scoreboard and compare the beat
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (teIf.te_valid && teIf.te_ready) begin
          beatsSeen++;
          if (expQ.size() == 0) begin
            checkOutput("unexpectedBeat", 64'd1, 64'd0);
          end else begin
            beat_t e;
            e = expQ.pop_front();
            checkOutput("beatUop", 64'(teIf.te_uop), 64'(e.uop));
            checkOutput("beatCommon", 64'(teIf.te_common), 64'(e.common));
            checkOutput("beatLast", 64'(teIf.te_last), 64'(e.last));
            checkOutput("uopPopOnBeat", 64'(uop_pop_o), 64'(e.hasUop));
          end
        end else if (uop_pop_o) begin
          checkOutput("uopPopNoHandshake", 64'(uop_pop_o), 64'd0);
        end
        if (common_pop_o) begin
          checkOutput("commonPopWhenEmpty", 64'(common_empty_i), 64'd0);
        end
        popCPend = common_pop_o;
        popUPend = uop_pop_o;
      end
    end
  end

  // Global time bound
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCommonPop(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_i);
      seen = common_pop_o;
    end
    if (!seen) checkOutput(name, 64'd0, 64'd1);
  endtask

  task automatic waitDrain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk_i);
      done = (expQ.size() == 0) && (commonQ.size() == 0);
    end
    if (!done) checkOutput(name, 64'(expQ.size()), 64'd0);
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Reset with both FIFOs holding data
    applyStimulus(mkCommon(2'd3, 8'd0), 2, 1'b1);
    applyStimulus(mkCommon(2'd1, 8'd5), 0, 1'b1);
    repeat (3) @(negedge clk_i);
    checkOutput("rstCommonPop", 64'(common_pop_o), 64'd0);
    checkOutput("rstUopPop", 64'(uop_pop_o), 64'd0);
    checkOutput("rstValid", 64'(teIf.te_valid), 64'd0);
    checkOutput("rstLast", 64'(teIf.te_last), 64'd0);
    checkOutput("rstCommon", 64'(teIf.te_common), 64'd0);
    checkOutput("rstUop", 64'(teIf.te_uop), 64'd0);
    checkOutput("rstError", 64'(error_o), 64'd0);

    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("c0CommonPop", 64'(common_pop_o), 64'd1);
    checkOutput("c0Valid", 64'(teIf.te_valid), 64'd0);
    @(negedge clk_i);
    checkOutput("c1Valid", 64'(teIf.te_valid), 64'd1);
    checkOutput("c1Last", 64'(teIf.te_last), 64'd0);
    checkOutput("c1UopPop", 64'(uop_pop_o), 64'd1);
    checkOutput("c1Priv", 64'(teIf.te_common.priv), 64'd3);
    @(negedge clk_i);
    checkOutput("c2Valid", 64'(teIf.te_valid), 64'd1);
    checkOutput("c2Last", 64'(teIf.te_last), 64'd1);
    checkOutput("c2UopPop", 64'(uop_pop_o), 64'd1);
`ifdef MURE_SEQ_B2B_EN
    checkOutput("c2B2bCommonPop", 64'(common_pop_o), 64'd1);
    @(negedge clk_i);
`else
    checkOutput("c2CommonPop", 64'(common_pop_o), 64'd0);
    @(negedge clk_i);
    checkOutput("c3BubbleValid", 64'(teIf.te_valid), 64'd0);
    checkOutput("c3CommonPop", 64'(common_pop_o), 64'd1);
    @(negedge clk_i);
`endif
    checkOutput("emptyValid", 64'(teIf.te_valid), 64'd1);
    checkOutput("emptyCause", 64'(teIf.te_common.cause), 64'd5);
    checkOutput("emptyUop", 64'(teIf.te_uop), 64'd0);
    checkOutput("emptyLast", 64'(teIf.te_last), 64'd1);
    checkOutput("emptyUopPop", 64'(uop_pop_o), 64'd0);
    waitDrain("drainBasic");

    // Backpressure on a one-uop block
    readyForce = 1'b0;
    @(negedge clk_i);
    applyStimulus(mkCommon(2'd0, 8'd2), 1, 1'b1);
    waitCommonPop("bpCommonPop");
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_i);
      checkOutput("bpValid", 64'(teIf.te_valid), 64'd1);
      checkOutput("bpNoPop", 64'(uop_pop_o), 64'd0);
      checkOutput("bpStable", 64'(teIf.te_uop), 64'(lastUop));
    end
    readyForce = 1'b1;
    @(negedge clk_i);
    checkOutput("bpPop", 64'(uop_pop_o), 64'd1);
    checkOutput("bpLast", 64'(teIf.te_last), 64'd1);
    waitDrain("drainBp");

    // Stall error with the uop withheld
    applyStimulus(mkCommon(2'd1, 8'd7), 1, 1'b0);
    waitCommonPop("stallCommonPop");
    repeat (3) @(negedge clk_i);
    checkOutput("stallValid", 64'(teIf.te_valid), 64'd0);
    checkOutput("stallErrEarly", 64'(error_o), 64'd0);
    repeat (2) @(negedge clk_i);
    checkOutput("stallErrSet", 64'(error_o), 64'd1);
    while (heldQ.size() > 0) uopQ.push_back(heldQ.pop_front());
    waitDrain("drainStall");
    checkOutput("errAfterUop", 64'(error_o), 64'd1);
    @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    @(negedge clk_i);
    checkOutput("errAfterFlush", 64'(error_o), 64'd1);

    // Flush in the first beat cycle of a block
    applyStimulus(mkCommon(2'd2, 8'd1), 1, 1'b1);
    applyStimulus(mkCommon(2'd2, 8'd9), 1, 1'b1);
    waitCommonPop("flushCommonPop");
    @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(negedge clk_i);
    checkOutput("flushCommonPop0", 64'(common_pop_o), 64'd0);
    checkOutput("flushUopPop0", 64'(uop_pop_o), 64'd0);
    checkOutput("flushValid0", 64'(teIf.te_valid), 64'd0);
    commonQ.delete(); uopQ.delete(); expQ.delete(); heldQ.delete();
    beatsExpected = beatsSeen;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    @(negedge clk_i);
    checkOutput("flushIdleValid", 64'(teIf.te_valid), 64'd0);
    checkOutput("flushIdleCommon", 64'(teIf.te_common), 64'd0);

    // Randomized traffic with random backpressure and clamped counts
    readyRandom = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_i);
      if (commonQ.size() < 4 && $urandom_range(0, 2) == 0) begin
        applyStimulus(mkCommon(2'($urandom), 8'($urandom)), $urandom_range(0, 3), 1'b1);
      end
    end
    waitDrain("drainRandom");
    checkOutput("beatCount", 64'(beatsSeen), 64'(beatsExpected));
    checkOutput("uopFifoEmpty", 64'(uopQ.size()), 64'd0);
    checkOutput("errStillSet", 64'(error_o), 64'd1);

    // Reset mid-block clears the sticky error
    readyRandom = 1'b0;
    readyForce  = 1'b0;
    applyStimulus(mkCommon(2'd3, 8'd3), 2, 1'b1);
    waitCommonPop("midRstCommonPop");
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    @(negedge clk_i);
    checkOutput("midRstValid", 64'(teIf.te_valid), 64'd0);
    checkOutput("midRstCommonPop", 64'(common_pop_o), 64'd0);
    checkOutput("midRstError", 64'(error_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
